sw_input_conditioner: RTL and testbench

Per-channel input conditioner for the board's slide switches and push-buttons. Each channel gets a two-flop synchronizer, a stable-count debouncer, single-cycle rise/fall pulses and a toggle latch. The block sits between the FPGA input pins and the combinational logic that consumes switch values, such as the gate-level lab blocks. Those consumers receive clean, registered levels instead of raw asynchronous pins.

---
 rtl/sw_input_conditioner_if.sv | 28 ++
 rtl/sw_input_conditioner.sv | 89 ++++++++
 tb/tb_sw_input_conditioner.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/sw_input_conditioner_if.sv
// Switch conditioner bus: raw pin inputs plus the conditioned per-channel outputs.
interface sw_input_conditioner_if #(
  parameter int N = 2
);
  logic [N-1:0] sw_raw;
  logic [N-1:0] sw_level;
  logic [N-1:0] sw_rise;
  logic [N-1:0] sw_fall;
  logic [N-1:0] sw_toggle;

  // Pin side: drives raw values and consumes the conditioned outputs.
  modport master (
    output sw_raw,
    input  sw_level,
    input  sw_rise,
    input  sw_fall,
    input  sw_toggle
  );

  // Conditioner side.
  modport slave (
    input  sw_raw,
    output sw_level,
    output sw_rise,
    output sw_fall,
    output sw_toggle
  );
endinterface

// File: rtl/sw_input_conditioner.sv
// Per-channel switch conditioner: 2-flop sync, stable-count debounce,
// rise/fall pulses and a toggle latch flipped on every rise.
//
// state         | meaning
// --------------+-------------------------------------------------------------
// ST_STABLE     | sync2 == sw_level, count held at 0
// ST_QUALIFYING | sync2 != sw_level, count running 0..STABLE_CYCLES-1
//
// The state is not stored separately; it is fully implied by sync2 vs level,
// so it is decoded combinationally from the registered channel state.
module sw_input_conditioner #(
  parameter int N             = 2,
  parameter int STABLE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset_n,
  sw_input_conditioner_if.slave sw
);

  localparam int              CW     = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_TC = CW'(STABLE_CYCLES - 1);

  typedef enum logic {
    ST_STABLE     = 1'b0,
    ST_QUALIFYING = 1'b1
  } ch_state_t;

  logic [N-1:0]  sync1;
  logic [N-1:0]  sync2;
  logic [N-1:0]  level_q;
  logic [N-1:0]  rise_q;
  logic [N-1:0]  fall_q;
  logic [N-1:0]  toggle_q;
  logic [CW-1:0] count_q [N];

  ch_state_t     state   [N];
  logic [CW-1:0] count_d [N];
  logic [N-1:0]  level_d;
  logic [N-1:0]  rise_d;
  logic [N-1:0]  fall_d;
  logic [N-1:0]  toggle_d;

  // Register all per-channel state; reset clears everything immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1    <= '0;
      sync2    <= '0;
      level_q  <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      toggle_q <= '0;
      for (int i = 0; i < N; i++) count_q[i] <= '0;
    end else begin
      sync1    <= sw.sw_raw;
      sync2    <= sync1;
      level_q  <= level_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      toggle_q <= toggle_d;
      for (int i = 0; i < N; i++) count_q[i] <= count_d[i];
    end
  end

  // Decode state and compute the next count/level; any agreement restarts qualification.
  always_comb begin
    level_d = level_q;
    for (int i = 0; i < N; i++) begin
      state[i]   = (sync2[i] != level_q[i]) ? ST_QUALIFYING : ST_STABLE;
      count_d[i] = '0;
      if (state[i] == ST_QUALIFYING) begin
        if (count_q[i] == CNT_TC) level_d[i] = sync2[i];
        else                      count_d[i] = count_q[i] + CW'(1);
      end
    end
  end

  // Edge pulses and toggle are registered alongside the level they describe.
  always_comb begin
    rise_d   = level_d & ~level_q;
    fall_d   = ~level_d & level_q;
    toggle_d = toggle_q ^ rise_d;
  end

  assign sw.sw_level  = level_q;
  assign sw.sw_rise   = rise_q;
  assign sw.sw_fall   = fall_q;
  assign sw.sw_toggle = toggle_q;

endmodule

// File: tb/tb_sw_input_conditioner.sv
// Directed bench for sw_input_conditioner with N=2, STABLE_CYCLES=4.
module tb_sw_input_conditioner;

  logic clk;
  logic reset_n;

  int n_vec;
  int n_miscmp;
  int rise_cnt [2];
  int fall_cnt [2];
  int both_hi;

  sw_input_conditioner_if #(.N(2)) sw_bus ();

  sw_input_conditioner #(
    .N             (2),
    .STABLE_CYCLES (4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .sw      (sw_bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge, sample 1 time unit later and tally pulses.
  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      for (int c = 0; c < 2; c++) begin
        rise_cnt[c] += int'(sw_bus.sw_rise[c]);
        fall_cnt[c] += int'(sw_bus.sw_fall[c]);
        if (sw_bus.sw_rise[c] && sw_bus.sw_fall[c]) both_hi++;
      end
    end
  endtask

  task automatic clr_cnt();
    for (int c = 0; c < 2; c++) begin
      rise_cnt[c] = 0;
      fall_cnt[c] = 0;
    end
  endtask

  initial begin
    n_vec    = 0;
    n_miscmp = 0;
    both_hi  = 0;
    clr_cnt();
    reset_n        = 1'b0;
    sw_bus.sw_raw  = 2'b00;
    tick(3);
    check_eq("rst_level",  32'(sw_bus.sw_level),  32'h0);
    check_eq("rst_rise",   32'(sw_bus.sw_rise),   32'h0);
    check_eq("rst_fall",   32'(sw_bus.sw_fall),   32'h0);
    check_eq("rst_toggle", 32'(sw_bus.sw_toggle), 32'h0);
    reset_n = 1'b1;
    tick(3);

    // Clean press on channel 0: accepted at E0+5.
    clr_cnt();
    sw_bus.sw_raw = 2'b01;
    tick(1);
    tick(4);
    check_eq("press_e4_level", 32'(sw_bus.sw_level), 32'h0);
    tick(1);
    check_eq("press_e5_level",  32'(sw_bus.sw_level),  32'h1);
    check_eq("press_e5_rise",   32'(sw_bus.sw_rise),   32'h1);
    check_eq("press_e5_fall",   32'(sw_bus.sw_fall),   32'h0);
    check_eq("press_e5_toggle", 32'(sw_bus.sw_toggle), 32'h1);
    tick(1);
    check_eq("press_e6_rise",  32'(sw_bus.sw_rise),  32'h0);
    check_eq("press_e6_level", 32'(sw_bus.sw_level), 32'h1);
    sw_bus.sw_raw = 2'b00;
    tick(10);
    check_eq("release0_level",  32'(sw_bus.sw_level),  32'h0);
    check_eq("release0_toggle", 32'(sw_bus.sw_toggle), 32'h1);
    check_eq("release0_fall",   32'(fall_cnt[0]),      32'd1);

    // Bounce 1,0,1,1,0 then hold 1.
    clr_cnt();
    sw_bus.sw_raw = 2'b01; tick(1);
    sw_bus.sw_raw = 2'b00; tick(1);
    sw_bus.sw_raw = 2'b01; tick(1);
    sw_bus.sw_raw = 2'b01; tick(1);
    sw_bus.sw_raw = 2'b00; tick(1);
    sw_bus.sw_raw = 2'b01;
    tick(1);
    tick(4);
    check_eq("bounce_e4_level", 32'(sw_bus.sw_level), 32'h0);
    check_eq("bounce_no_pulse", 32'(rise_cnt[0]),     32'd0);
    tick(1);
    check_eq("bounce_e5_rise",   32'(sw_bus.sw_rise),   32'h1);
    check_eq("bounce_e5_toggle", 32'(sw_bus.sw_toggle), 32'h0);
    sw_bus.sw_raw = 2'b00;
    tick(10);
    check_eq("bounce_rise_cnt", 32'(rise_cnt[0]), 32'd1);
    check_eq("bounce_fall_cnt", 32'(fall_cnt[0]), 32'd1);

    // Press / release / press on channel 1.
    clr_cnt();
    sw_bus.sw_raw = 2'b10; tick(10);
    check_eq("ch1_tog_a", 32'(sw_bus.sw_toggle[1]), 32'h1);
    sw_bus.sw_raw = 2'b00; tick(10);
    check_eq("ch1_tog_b",   32'(sw_bus.sw_toggle[1]), 32'h1);
    check_eq("ch1_level_b", 32'(sw_bus.sw_level),     32'h0);
    sw_bus.sw_raw = 2'b10; tick(10);
    check_eq("ch1_tog_c",  32'(sw_bus.sw_toggle[1]), 32'h0);
    check_eq("ch1_rises",  32'(rise_cnt[1]),         32'd2);
    check_eq("ch1_falls",  32'(fall_cnt[1]),         32'd1);
    check_eq("ch1_ch0_quiet", 32'(rise_cnt[0] + fall_cnt[0]), 32'd0);
    sw_bus.sw_raw = 2'b00; tick(10);

    // Both channels together.
    sw_bus.sw_raw = 2'b11;
    tick(1);
    tick(4);
    check_eq("sim_e4_rise", 32'(sw_bus.sw_rise), 32'h0);
    tick(1);
    check_eq("sim_rise",   32'(sw_bus.sw_rise),   32'h3);
    check_eq("sim_level",  32'(sw_bus.sw_level),  32'h3);
    check_eq("sim_toggle", 32'(sw_bus.sw_toggle), 32'h3);
    sw_bus.sw_raw = 2'b00;
    tick(1);
    tick(5);
    check_eq("sim_fall",       32'(sw_bus.sw_fall),   32'h3);
    check_eq("sim_fall_rise",  32'(sw_bus.sw_rise),   32'h0);
    check_eq("sim_fall_toggle", 32'(sw_bus.sw_toggle), 32'h3);
    tick(3);

    // Reset in the middle of qualification.
    clr_cnt();
    sw_bus.sw_raw = 2'b01;
    tick(3);
    reset_n = 1'b0;
    #1;
    check_eq("rstq_level",  32'(sw_bus.sw_level),  32'h0);
    check_eq("rstq_toggle", 32'(sw_bus.sw_toggle), 32'h0);
    tick(2);
    check_eq("rstq_hold_level", 32'(sw_bus.sw_level), 32'h0);
    check_eq("rstq_hold_pulse", 32'(sw_bus.sw_rise | sw_bus.sw_fall), 32'h0);
    check_eq("rstq_no_rise",    32'(rise_cnt[0]), 32'd0);
    reset_n = 1'b1;
    tick(1);
    tick(4);
    check_eq("rstq_e4_level", 32'(sw_bus.sw_level), 32'h0);
    tick(1);
    check_eq("rstq_e5_rise",  32'(sw_bus.sw_rise),  32'h1);
    check_eq("rstq_e5_level", 32'(sw_bus.sw_level), 32'h1);
    tick(10);
    check_eq("rstq_rise_cnt", 32'(rise_cnt[0]), 32'd1);

    // Threshold: 3-cycle pulse ignored, 4-cycle pulse accepted.
    sw_bus.sw_raw = 2'b00;
    tick(10);
    clr_cnt();
    sw_bus.sw_raw = 2'b01; tick(3);
    sw_bus.sw_raw = 2'b00; tick(10);
    check_eq("thr3_rise_cnt", 32'(rise_cnt[0]),    32'd0);
    check_eq("thr3_level",    32'(sw_bus.sw_level), 32'h0);
    sw_bus.sw_raw = 2'b01; tick(4);
    sw_bus.sw_raw = 2'b00;
    tick(1);
    check_eq("thr4_e4_level", 32'(sw_bus.sw_level), 32'h0);
    tick(1);
    check_eq("thr4_e5_rise",  32'(sw_bus.sw_rise),  32'h1);
    tick(12);
    check_eq("thr4_rise_cnt", 32'(rise_cnt[0]),     32'd1);
    check_eq("thr4_fall_cnt", 32'(fall_cnt[0]),     32'd1);
    check_eq("thr4_level",    32'(sw_bus.sw_level), 32'h0);

    check_eq("rise_fall_exclusive", 32'(both_hi), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
